uart_frame_tx: RTL

- Packetizer that sits directly upstream of the UART byte transmitter.
- Buffers 16-bit PPG samples in a small FIFO and wraps each sample in a byte frame.
- Drives the transmitter one byte at a time using its enable/result handshake.
- Lets the sample producer write bursts without waiting on the 115200 bps line.

---
 rtl/uart_frame_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_frame_tx.sv
// FIFO-buffered framer: wraps each 16-bit sample as HDR, hi, lo and feeds a byte UART one byte at a time.
// Define UART_FRAME_CKSUM_EN to append an 8-bit additive checksum byte to every frame.
module uart_frame_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter int          ADDR_W     = 3,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic        sysClk,
    input  logic        rst,
    input  logic        sampleValid,
    input  logic [15:0] sampleData,
    output logic        sampleReady,
    output logic        txEnable,
    output logic [7:0]  txData,
    input  logic        txResult,
    output logic        busy,
    output logic        frameDone,
    output logic        overflow
);
    // state | meaning
    // IDLE  | txEnable low; pops FIFO head into shadow when a sample is waiting
    // SEND  | txEnable high with txData held until the transmitter reports txResult
    // GAP   | single low cycle between bytes; advances byte index or closes the frame
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

`ifdef UART_FRAME_CKSUM_EN
    localparam logic [1:0] LAST = 2'd3;
`else
    localparam logic [1:0] LAST = 2'd2;
`endif

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [15:0]       mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [1:0]        state;
    logic [1:0]        byte_idx;
    logic [15:0]       shadow;
    logic [7:0]        next_byte;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign push        = sampleValid && !full;
    assign pop         = (state == IDLE) && !empty;
    assign sampleReady = !full;
    assign busy        = (state != IDLE) || !empty;

`ifdef UART_FRAME_CKSUM_EN
    logic [7:0] cksum;

    // Checksum is taken from the popped word so it is ready before the last byte.
    always_ff @(posedge sysClk) begin
        if (pop) cksum <= HDR_BYTE + mem[rd_ptr][15:8] + mem[rd_ptr][7:0];
    end
`endif

    always_ff @(posedge sysClk) begin
        if (push) mem[wr_ptr] <= sampleData;
        if (pop)  shadow      <= mem[rd_ptr];
    end

    // byte_idx still names the byte just sent, so select the one after it.
    always_comb begin
        next_byte = shadow[15:8];
        case (byte_idx)
            2'd0:    next_byte = shadow[15:8];
            2'd1:    next_byte = shadow[7:0];
`ifdef UART_FRAME_CKSUM_EN
            default: next_byte = cksum;
`else
            default: next_byte = shadow[15:8];
`endif
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            byte_idx  <= 2'd0;
            txEnable  <= 1'b0;
            txData    <= 8'hFF;
            frameDone <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (sampleValid && full) overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (!empty) begin
                        byte_idx <= 2'd0;
                        txData   <= HDR_BYTE;
                        txEnable <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (txResult) begin
                        txEnable <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (byte_idx == LAST) begin
                        frameDone <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        txData   <= next_byte;
                        txEnable <= 1'b1;
                        state    <= SEND;
                    end
                end
                default: begin
                    txEnable <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
